// File: rtl/dual_port_memory_module.sv
// True dual-port synchronous RAM with per-byte write enables.
// The read-during-write mode and the optional output register are set by parameters.
// Storage is split into one array per byte lane, so byte-enable writes map onto plain RAM.
// Both ports read the old word when they hit the same address in one cycle.
// When both ports write the same lane of the same word, port A's data is stored.
module dual_port_memory_module #(
  parameter int width      = 32,
  parameter int depth      = 8,
  parameter int byte_width = 8,
  parameter int write_mode = 0,
  parameter int out_reg    = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          a_en,
  input  logic [width/byte_width-1:0]   a_we,
  input  logic [$clog2(depth)-1:0]      a_addr,
  input  logic [width-1:0]              a_din,
  output logic [width-1:0]              a_dout,
  output logic                          a_valid,
  input  logic                          b_en,
  input  logic [width/byte_width-1:0]   b_we,
  input  logic [$clog2(depth)-1:0]      b_addr,
  input  logic [width-1:0]              b_din,
  output logic [width-1:0]              b_dout,
  output logic                          b_valid,
  output logic                          collision
);

  localparam int nbytes          = width / byte_width;
  localparam int aw              = $clog2(depth);
  localparam int mode_write_first = 1;
  localparam int mode_no_change   = 2;

  logic a_addr_ok, b_addr_ok;
  logic a_wr_any, b_wr_any;
  logic a_wr_ok, b_wr_ok;
  logic a_hold, b_hold;
  logic same_addr;

  logic [width-1:0] a_q_word, b_q_word;
  logic             a_v_reg, b_v_reg, col_reg;

  // Out-of-range addresses only exist when depth is not a power of two
  generate
    if ((1 << aw) == depth) begin : g_pow2
      assign a_addr_ok = 1'b1;
      assign b_addr_ok = 1'b1;
    end else begin : g_npow2
      assign a_addr_ok = (32'(a_addr) < 32'(depth));
      assign b_addr_ok = (32'(b_addr) < 32'(depth));
    end
  endgenerate

  assign a_wr_any  = |a_we;
  assign b_wr_any  = |b_we;
  // Reset blocks all accesses; out-of-range writes are dropped
  assign a_wr_ok   = rst_n & a_en & a_addr_ok;
  assign b_wr_ok   = rst_n & b_en & b_addr_ok;
  // Under NO_CHANGE a write access leaves the read register untouched
  assign a_hold    = (write_mode == mode_no_change) && a_wr_any;
  assign b_hold    = (write_mode == mode_no_change) && b_wr_any;
  assign same_addr = (a_addr == b_addr);

  generate
    for (genvar gi = 0; gi < nbytes; gi++) begin : g_lane
      logic [byte_width-1:0] mem [depth];
      logic [byte_width-1:0] a_din_lane, b_din_lane;
      logic [byte_width-1:0] a_q_lane_reg, b_q_lane_reg;
      logic                  a_lane_we, b_lane_we;

      assign a_din_lane = a_din[gi*byte_width +: byte_width];
      assign b_din_lane = b_din[gi*byte_width +: byte_width];
      assign a_lane_we  = a_wr_ok & a_we[gi];
      // Port B yields this lane when port A writes it at the same word
      assign b_lane_we  = b_wr_ok & b_we[gi] & ~(a_lane_we & same_addr);

      // Lane storage write from both ports
      always_ff @(posedge clk) begin
        if (a_lane_we) mem[a_addr] <= a_din_lane;
        if (b_lane_we) mem[b_addr] <= b_din_lane;
      end

      // Port A lane read register: read-first by default, own data on write-first
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_q_lane_reg <= '0;
        end else if (a_en && !a_hold) begin
          if (!a_addr_ok)
            a_q_lane_reg <= '0;
          else if (write_mode == mode_write_first && a_we[gi])
            a_q_lane_reg <= a_din_lane;
          else
            a_q_lane_reg <= mem[a_addr];
        end
      end

      // Port B lane read register, same rules as port A
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          b_q_lane_reg <= '0;
        end else if (b_en && !b_hold) begin
          if (!b_addr_ok)
            b_q_lane_reg <= '0;
          else if (write_mode == mode_write_first && b_we[gi])
            b_q_lane_reg <= b_din_lane;
          else
            b_q_lane_reg <= mem[b_addr];
        end
      end

      assign a_q_word[gi*byte_width +: byte_width] = a_q_lane_reg;
      assign b_q_word[gi*byte_width +: byte_width] = b_q_lane_reg;
    end
  endgenerate

  // First-stage valid and collision flags, aligned with the read registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_v_reg <= 1'b0;
      b_v_reg <= 1'b0;
      col_reg <= 1'b0;
    end else begin
      a_v_reg <= a_en & ~a_hold;
      b_v_reg <= b_en & ~b_hold;
      col_reg <= a_en & b_en & same_addr & (a_wr_any | b_wr_any);
    end
  end

  generate
    if (out_reg != 0) begin : g_out_reg
      logic [width-1:0] a_dout_reg, b_dout_reg;
      logic             a_valid_reg, b_valid_reg, col_out_reg;

      // Free-running second stage; cleared by reset so in-flight reads are dropped
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_dout_reg  <= '0;
          b_dout_reg  <= '0;
          a_valid_reg <= 1'b0;
          b_valid_reg <= 1'b0;
          col_out_reg <= 1'b0;
        end else begin
          a_dout_reg  <= a_q_word;
          b_dout_reg  <= b_q_word;
          a_valid_reg <= a_v_reg;
          b_valid_reg <= b_v_reg;
          col_out_reg <= col_reg;
        end
      end

      assign a_dout    = a_dout_reg;
      assign b_dout    = b_dout_reg;
      assign a_valid   = a_valid_reg;
      assign b_valid   = b_valid_reg;
      assign collision = col_out_reg;
    end else begin : g_no_out_reg
      assign a_dout    = a_q_word;
      assign b_dout    = b_q_word;
      assign a_valid   = a_v_reg;
      assign b_valid   = b_v_reg;
      assign collision = col_reg;
    end
  endgenerate

endmodule

// File: doc/dual_port_memory_module.md
Name: dual_port_memory_module

Overview:
- Parametrised true dual-port synchronous RAM. Successor to the single-port memory module.
- Two independent read/write ports, A and B, share one clock.
- Adds per-byte write enables, a selectable read-during-write mode, an optional output pipeline register, read-valid tracking and cross-port collision flagging.
- Used as the shared buffer between producer and consumer datapaths in the SRAM subsystem.

Parameters:
- width, 32: word width in bits. Must be a multiple of byte_width.
- depth, 8: number of words. Must be ≥2.
- byte_width, 8: bits per write-enable lane. nbytes = width/byte_width.
- write_mode, 0: same-port read-during-write mode. 0 = READ_FIRST, 1 = WRITE_FIRST, 2 = NO_CHANGE.
- out_reg, 0: 0 gives 1-cycle read latency. 1 adds an output register, giving 2-cycle latency.

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  synchronous active-low reset
- a_en  in  1  port A access enable
- a_we  in  nbytes  port A byte write enables
- a_addr  in  $clog2(depth)  port A address
- a_din  in  width  port A write data
- a_dout  out  width  port A read data
- a_valid  out  1  a_dout holds fresh read data this cycle
- b_en, b_we, b_addr, b_din, b_dout, b_valid: identical to port A, for port B
- collision  out  1  cross-port address collision, aligned with the corresponding dout/valid

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - a_dout, b_dout = 0; a_valid, b_valid = 0; collision = 0; all pipeline stages cleared.
  - Memory contents are not cleared and are retained.
  - Accesses presented while rst_n=0 are ignored: no writes, no reads issued.
  - A read in flight when reset asserts is dropped; its valid never appears.
- Access types per port, per edge:
  - Idle: en=0. dout holds its value; valid=0 at the output stage.
  - Read: en=1, we=0. Fetches the word at addr.
  - Write: en=1, we≠0. For each lane i with we[i]=1, mem[addr][i*byte_width +: byte_width] ← din lane i. Lanes with we[i]=0 keep their old value.
- Latency:
  - out_reg=0: data and valid appear on the edge that samples the access, i.e. visible the following cycle.
  - out_reg=1: data and valid appear one edge later.
  - Back-to-back accesses give one result per cycle. No stalls; no backpressure.
- Same-port read-during-write (Write access), by write_mode:
  - READ_FIRST: dout = old word; valid=1.
  - WRITE_FIRST: dout = merged new word (enabled lanes from din, others old); valid=1.
  - NO_CHANGE: dout holds its previous value; valid=0.
- Cross-port collision: a_en & b_en & (a_addr==b_addr) & (a_we≠0 | b_we≠0).
  - Both ports write: lanes enabled on only one port take that port's data. Lanes enabled on both take port A's data (A wins).
  - One port writes, the other reads: the reader gets the old word (read-first across ports) regardless of write_mode.
  - collision pulses high for one cycle, with the same latency as dout/valid (1 or 2 cycles per out_reg). It is 0 when the addresses differ or both ports only read.
- Address range: addr ≥ depth is possible only when depth is not a power of 2.
  - Writes to such an address are discarded.
  - Reads from such an address return 0 with valid=1.
- out_reg=1 pipeline:
  - The second stage always advances. No clock enable.
  - Under NO_CHANGE, a held value propagates unchanged with valid=0.
- Memory initial contents: undefined. The bench must write before reading.

Test Plan:
- Basic, width=32, depth=8, out_reg=0: write A addr3=0xDEADBEEF, we=4'hF; next cycle read B addr3 → b_dout=0xDEADBEEF, b_valid=1 one cycle after the read; collision=0.
- Byte enables: mem[5]=0x11223344; write A addr5, din=0xAABBCCDD, we=4'b0101; read addr5 → 0x11BB33DD.
- write_mode sweep, mem[2]=0x0, A writes 0x55 to addr2:
  - READ_FIRST → a_dout=0x0, a_valid=1.
  - WRITE_FIRST → a_dout=0x55, a_valid=1.
  - NO_CHANGE → a_dout unchanged, a_valid=0.
- Cross-port collision, mem[7]=0xFFFFFFFF:
  - Same cycle: A writes 0x01020304 we=4'b0011, B writes 0xA0B0C0D0 we=4'b0110 → mem[7]=0xFFB00304; collision=1 for one cycle.
  - Next: A writes addr7 while B reads addr7 → b_dout = old word; collision=1.
- out_reg=1: read addr3 on cycle N → a_valid and a_dout at cycle N+2, not N+1. Back-to-back reads of addr0..7 → 8 consecutive valid cycles in address order.
- Reset mid-operation: issue a read with out_reg=1, then assert rst_n=0 on the next edge → a_valid never rises, dout=0. A write presented during reset leaves the memory unchanged. Data written before reset reads back intact after rst_n=1.
